photonic_receiver: RTL and testbench

// - Receive stage opposite the per-node transmitter on the shared photonic bus.
// - Samples frames {src_id, data, dest_id} (dest_id in LSBs, src_id in MSBs) qualified by rx_valid.
// - Keeps frames whose dest_id equals NODE_ID and queues {src_id, data} in a show-ahead FIFO.
// - The local core drains the FIFO through a valid/ready-style pop interface.

---
 rtl/photonic_receiver.sv | 105 ++++++++++
 tb/tb_photonic_receiver.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/photonic_receiver.sv
// Photonic bus receive stage: filters frames addressed to NODE_ID and queues {src, data} in a show-ahead FIFO.
// Optional macro PHOTONIC_RX_BROADCAST_EN: also accept frames whose dest_id is all ones.
module photonic_receiver #(
   parameter int ID_WIDTH   = 1,
   parameter int DATA_WIDTH = 1,
   parameter int NODE_ID    = 0,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [2*ID_WIDTH+DATA_WIDTH-1:0] rx_in,
   input  logic                            rx_valid,
   input  logic                            rd_en,
   output logic [DATA_WIDTH-1:0]           data_out,
   output logic [ID_WIDTH-1:0]             src_id_out,
   output logic                            data_valid,
   output logic                            fifo_full,
   output logic [7:0]                      drop_count
);

   localparam int FW    = 2*ID_WIDTH + DATA_WIDTH;
   localparam int EW    = ID_WIDTH + DATA_WIDTH;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [ID_WIDTH-1:0] NODE_ADDR = ID_WIDTH'(NODE_ID);
   localparam logic [CNT_W-1:0]    DEPTH_CNT = CNT_W'(FIFO_DEPTH);

   logic [FW-1:0]    stage_frame_q, stage_frame_d;
   logic             stage_valid_q, stage_valid_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [7:0]       drop_q, drop_d;
   logic [EW-1:0]    mem_q [FIFO_DEPTH];

   logic [ID_WIDTH-1:0] stage_dest;
   logic [EW-1:0]       stage_entry;
   logic [EW-1:0]       head;
   logic                match, full, pop, push, drop;

   // NOTE: every signal gets a default at the top of always_comb so no path leaves one unassigned and infers a latch.
   always_comb begin
      stage_frame_d = rx_in;
      stage_valid_d = rx_valid;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q;
      drop_d        = drop_q;

      // The upper bits of a frame are already laid out as {src, data}.
      stage_dest  = stage_frame_q[ID_WIDTH-1:0];
      stage_entry = stage_frame_q[FW-1:ID_WIDTH];
`ifdef PHOTONIC_RX_BROADCAST_EN
      match = stage_valid_q && ((stage_dest == NODE_ADDR) || (stage_dest == '1));
`else
      match = stage_valid_q && (stage_dest == NODE_ADDR);
`endif
      full = (count_q == DEPTH_CNT);
      pop  = rd_en && (count_q != '0);
      push = match && (!full || pop);
      drop = match && full && !pop;

      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      if (drop && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      stage_frame_q <= stage_frame_d;
      if (rst) begin
         stage_valid_q <= 1'b0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         drop_q        <= '0;
      end else begin
         stage_valid_q <= stage_valid_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         drop_q        <= drop_d;
      end
   end

   // NOTE: the storage array has no reset; entries are only visible through count, so stale contents are harmless.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= stage_entry;
   end

   always_comb begin
      head       = mem_q[rd_ptr_q];
      data_valid = (count_q != '0);
      fifo_full  = full;
      drop_count = drop_q;
      data_out   = data_valid ? head[DATA_WIDTH-1:0]  : '0;
      src_id_out = data_valid ? head[EW-1:DATA_WIDTH] : '0;
   end

endmodule

// File: tb/tb_photonic_receiver.sv
// Self-checking bench for photonic_receiver: directed vector table, corner sequences and random traffic vs a queue model.
module tb_photonic_receiver;

   localparam int IDW   = 2;
   localparam int DW    = 8;
   localparam int NID   = 1;
   localparam int DEPTH = 4;
   localparam int FW    = 2*IDW + DW;
`ifdef PHOTONIC_RX_BROADCAST_EN
   localparam bit BC = 1'b1;
`else
   localparam bit BC = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst, rx_valid, rd_en;
   logic [FW-1:0] rx_in;
   logic [DW-1:0] data_out;
   logic [IDW-1:0] src_id_out;
   logic          data_valid, fifo_full;
   logic [7:0]    drop_count;

   always #5 clk = ~clk;

   photonic_receiver #(.ID_WIDTH(IDW), .DATA_WIDTH(DW), .NODE_ID(NID), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .rx_in(rx_in), .rx_valid(rx_valid), .rd_en(rd_en),
      .data_out(data_out), .src_id_out(src_id_out), .data_valid(data_valid),
      .fifo_full(fifo_full), .drop_count(drop_count)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: queue of {src, data}, one-cycle stage, saturating drop counter.
   logic [IDW+DW-1:0] m_q[$];
   logic [FW-1:0]     m_stage_f = '0;
   logic              m_stage_v = 1'b0;
   int                m_drop    = 0;

   typedef struct {
      logic          rst;
      logic [FW-1:0] rx;
      logic          v;
      logic          rd;
      logic          e_valid;
      logic [DW-1:0] e_data;
      logic [IDW-1:0] e_src;
      logic          e_full;
      logic [7:0]    e_drop;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [FW-1:0] frame(input int src, input int data, input int dest);
      return {IDW'(src), DW'(data), IDW'(dest)};
   endfunction

   task automatic model_edge();
      bit pop, match, space;
      int dest;
      if (rst) begin
         m_q.delete();
         m_drop = 0;
         m_stage_v = 1'b0;
      end else begin
         dest  = int'(m_stage_f[IDW-1:0]);
         pop   = rd_en && (m_q.size() > 0);
         match = m_stage_v && ((dest == NID) || (BC && dest == (1 << IDW) - 1));
         space = (m_q.size() < DEPTH) || pop;
         if (pop) void'(m_q.pop_front());
         if (match && space) m_q.push_back(m_stage_f[FW-1:IDW]);
         else if (match && m_drop < 255) m_drop++;
         m_stage_v = rx_valid;
      end
      m_stage_f = rx_in;
   endtask

   task automatic check_model(input string tag);
      logic [IDW+DW-1:0] h;
      bit v;
      v = (m_q.size() != 0);
      h = v ? m_q[0] : '0;
      check({tag, ".valid"}, 32'(data_valid), 32'(v));
      check({tag, ".data"},  32'(data_out),   32'(h[DW-1:0]));
      check({tag, ".src"},   32'(src_id_out), 32'(h[IDW+DW-1:DW]));
      check({tag, ".full"},  32'(fifo_full),  32'(m_q.size() == DEPTH));
      check({tag, ".drop"},  32'(drop_count), 32'(m_drop));
   endtask

   // Drive inputs, take one edge, update the model, then compare 1 ns after the edge.
   task automatic step(input logic r, input logic [FW-1:0] f, input logic v, input logic rd, input string tag);
      rst = r; rx_in = f; rx_valid = v; rd_en = rd;
      @(posedge clk);
      model_edge();
      #1;
      check_model(tag);
   endtask

   initial begin
      rst = 1'b1; rx_in = '0; rx_valid = 1'b0; rd_en = 1'b0;

      // Directed vectors: outputs are checked right after the edge closing each row's cycle.
      vecs[0]  = '{1'b1, 12'h000, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 8'd0};
      vecs[1]  = '{1'b0, 12'hA95, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 8'd0};
      vecs[2]  = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 8'hA5, 2'd2, 1'b0, 8'd0};
      vecs[3]  = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 8'd0};
      vecs[4]  = '{1'b0, 12'hA96, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 8'd0};
      vecs[5]  = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 8'd0};
      vecs[6]  = '{1'b0, 12'hA95, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 8'd0};
      vecs[7]  = '{1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 8'd0};
      vecs[8]  = '{1'b0, 12'h96B, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 8'd0};
      vecs[9]  = '{1'b0, 12'h000, 1'b0, 1'b0, BC, BC ? 8'h5A : 8'h00, BC ? 2'd2 : 2'd0, 1'b0, 8'd0};
      vecs[10] = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 8'd0};

      for (int i = 0; i < 11; i++) begin
         step(vecs[i].rst, vecs[i].rx, vecs[i].v, vecs[i].rd, $sformatf("vec%0d", i));
         check($sformatf("vec%0d.tvalid", i), 32'(data_valid), 32'(vecs[i].e_valid));
         check($sformatf("vec%0d.tdata", i),  32'(data_out),   32'(vecs[i].e_data));
         check($sformatf("vec%0d.tsrc", i),   32'(src_id_out), 32'(vecs[i].e_src));
         check($sformatf("vec%0d.tfull", i),  32'(fifo_full),  32'(vecs[i].e_full));
         check($sformatf("vec%0d.tdrop", i),  32'(drop_count), 32'(vecs[i].e_drop));
      end

      // Overflow: six back-to-back matching frames, no pops.
      step(1'b1, '0, 1'b0, 1'b0, "ovf_rst");
      for (int d = 1; d <= 6; d++) step(1'b0, frame(3, d, NID), 1'b1, 1'b0, "ovf_fill");
      step(1'b0, '0, 1'b0, 1'b0, "ovf_idle");
      step(1'b0, '0, 1'b0, 1'b0, "ovf_idle");
      check("ovf.full", 32'(fifo_full), 32'd1);
      check("ovf.drop", 32'(drop_count), 32'd2);
      for (int d = 1; d <= 4; d++) begin
         check("ovf.order", 32'(data_out), 32'(d));
         step(1'b0, '0, 1'b0, 1'b1, "ovf_pop");
      end
      check("ovf.empty", 32'(data_valid), 32'd0);

      // Full plus pop: matching frame reaches stage 2 while the core pops.
      step(1'b1, '0, 1'b0, 1'b0, "fp_rst");
      for (int d = 0; d < 4; d++) step(1'b0, frame(1, 8'h10 + d, NID), 1'b1, 1'b0, "fp_fill");
      step(1'b0, '0, 1'b0, 1'b0, "fp_idle");
      step(1'b0, frame(2, 8'h77, NID), 1'b1, 1'b0, "fp_stage");
      step(1'b0, '0, 1'b0, 1'b1, "fp_both");
      check("fp.full", 32'(fifo_full), 32'd1);
      check("fp.drop", 32'(drop_count), 32'd0);
      for (int d = 0; d < 4; d++) begin
         check("fp.order", 32'(data_out), (d == 3) ? 32'h77 : 32'(8'h11 + d));
         step(1'b0, '0, 1'b0, 1'b1, "fp_pop");
      end

      // Wrap: continuous write/pop pairs across several pointer wraps.
      step(1'b1, '0, 1'b0, 1'b0, "wr_rst");
      for (int i = 0; i < 12; i++) step(1'b0, frame(i % 4, 8'h20 + i, NID), 1'b1, i >= 2, "wrap");
      step(1'b0, '0, 1'b0, 1'b1, "wrap_tail");
      step(1'b0, '0, 1'b0, 1'b1, "wrap_tail");
      check("wrap.empty", 32'(data_valid), 32'd0);

      // Reset with three entries queued.
      for (int d = 0; d < 3; d++) step(1'b0, frame(1, 8'hC0 + d, NID), 1'b1, 1'b0, "rq_fill");
      step(1'b0, '0, 1'b0, 1'b0, "rq_idle");
      check("rq.valid", 32'(data_valid), 32'd1);
      step(1'b1, '0, 1'b0, 1'b0, "rq_rst");
      check("rq.rvalid", 32'(data_valid), 32'd0);
      check("rq.rdata",  32'(data_out),   32'd0);
      check("rq.rdrop",  32'(drop_count), 32'd0);

      // Drop counter saturation.
      for (int i = 0; i < 270; i++) step(1'b0, frame(0, i, NID), 1'b1, 1'b0, "sat");
      step(1'b0, '0, 1'b0, 1'b0, "sat_idle");
      check("sat.drop", 32'(drop_count), 32'd255);

      // Random traffic against the model.
      step(1'b1, '0, 1'b0, 1'b0, "rnd_rst");
      for (int i = 0; i < 600; i++)
         step($urandom_range(0, 79) == 0, FW'($urandom), $urandom_range(0, 3) != 0,
              $urandom_range(0, 2) == 0, "rnd");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
